// File: rtl/instr_store.sv
// Instruction RAM with a byte-stream program loader. Serves NOP until a
// complete program is present, and for PCs past the loaded length.
module instr_store #(
  parameter int         DEPTH = 256,
  parameter logic [7:0] NOP   = 8'hC0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  output logic [8:0] load_count,
  output logic [7:0] checksum,
  output logic       overflow_err,
  output logic       cpu_run,
  input  logic [7:0] pc_address,
  output logic [7:0] instruction
);

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  localparam logic [8:0] LAST_IDX = 9'(DEPTH - 1);

  state_t     r_state;
  logic [8:0] r_count;
  logic [7:0] r_sum;
  logic       r_ovf;
  logic       r_ready;
  logic       r_run;
  logic [7:0] r_mem [DEPTH];

  logic       w_accept;
  logic       w_hit;

  // load_start outranks a byte presented in the same cycle
  assign w_accept = load_valid & r_ready & ~load_start;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= EMPTY;
      r_count <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_ready <= 1'b0;
      r_run   <= 1'b0;
    end else if (load_start) begin
      r_state <= LOAD;
      r_count <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_ready <= 1'b1;
      r_run   <= 1'b0;
    end else if (w_accept) begin
      r_count <= r_count + 9'd1;
      r_sum   <= r_sum + load_data;
      if (load_last || r_count == LAST_IDX) begin
        r_state <= RUN;
        r_ready <= 1'b0;
        r_run   <= 1'b1;
        r_ovf   <= ~load_last;
      end
    end
  end

  // RAM is deliberately not reset; the reset gate only blocks a write in the reset cycle
  always_ff @(posedge clock) begin
    if (reset && w_accept) begin
      r_mem[r_count[7:0]] <= load_data;
    end
  end

  assign w_hit       = (r_state == RUN) && ({1'b0, pc_address} < r_count);
  assign instruction = w_hit ? r_mem[pc_address] : NOP;

  assign load_ready   = r_ready;
  assign load_count   = r_count;
  assign checksum     = r_sum;
  assign overflow_err = r_ovf;
  assign cpu_run      = r_run;

endmodule
